// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two valid/ready
// requesters. Operands are registered before the ALU, and results are registered after it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_cmd0,
  input  logic [2:0]       req_cmd1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  input  logic             resp_ready0,
  input  logic             resp_ready1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carryout,
  output logic             resp_overflow,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       op_cmd_q, op_cmd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [15:0]      ops_done_q, ops_done_d;

  logic win1;
  logic accept;
  logic resp_hs;

  // Requester 1 wins when it is alone, or on a tie when 0 was served last.
  assign win1    = req_valid1 & (~req_valid0 | ~last_grant_q);
  assign accept  = (state_q == IDLE) & (req_valid0 | req_valid1);
  assign resp_hs = (state_q == RESP) & (owner_q ? resp_ready1 : resp_ready0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = EXEC;
      EXEC:                 state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready0  = (state_q == IDLE) & req_valid0 & ~win1;
    req_ready1  = (state_q == IDLE) & win1;
    resp_valid0 = (state_q == RESP) & ~owner_q;
    resp_valid1 = (state_q == RESP) & owner_q;
    busy        = (state_q != IDLE);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_cmd_d     = op_cmd_q;
    res_d        = res_q;
    carry_d      = carry_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    ops_done_d   = ops_done_q;
    if (accept) begin
      owner_d  = win1;
      op_a_d   = win1 ? req_a1 : req_a0;
      op_b_d   = win1 ? req_b1 : req_b0;
      op_cmd_d = win1 ? req_cmd1 : req_cmd0;
    end
    if (state_q == EXEC) begin
      res_d   = alu_result;
      carry_d = alu_carryout;
      ovf_d   = alu_overflow;
      zero_d  = alu_zero;
    end
    if (resp_hs) begin
      last_grant_d = owner_q;
      ops_done_d   = ops_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cmd_q     <= 3'd0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      ops_done_q   <= 16'd0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_cmd_q     <= op_cmd_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_a         = op_a_q;
  assign alu_b         = op_b_q;
  assign alu_cmd       = op_cmd_q;
  assign resp_result   = res_q;
  assign resp_carryout = carry_q;
  assign resp_overflow = ovf_q;
  assign resp_zero     = zero_q;
  assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port, directed scenarios
// and a randomized run checked against an arbitration/count model.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_cmd0, req_cmd1;
  logic        resp_valid0, resp_valid1;
  logic        resp_ready0, resp_ready1;
  logic [31:0] resp_result;
  logic        resp_carryout, resp_overflow, resp_zero;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_overflow, alu_zero;
  logic        busy;
  logic [15:0] ops_done;

  int          vectors;
  int          miscompares;
  logic        model_last;
  logic [15:0] exp_ops;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .resp_result(resp_result), .resp_carryout(resp_carryout),
    .resp_overflow(resp_overflow), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {carry, overflow, zero, result}.
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] cmd);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = 33'd0; c = 1'b0; v = 1'b0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, v, (r == 32'd0), r};
  endfunction

  assign {alu_carryout, alu_overflow, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_cmd);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid0 = 1'b1; req_a0 = 32'd3; req_b0 = 32'd4; req_cmd0 = 3'd0;
    tick; tick;
    reset = 1'b0; req_valid0 = 1'b0;
    model_last = 1'b1; exp_ops = 16'd0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if ({resp_valid0, resp_valid1} !== 2'b00) begin miscompares++; $display("FAIL reset_resp_valid got %b exp 00", {resp_valid0, resp_valid1}); end
    vectors++; if (ops_done !== 16'd0) begin miscompares++; $display("FAIL reset_ops_done got %0d exp 0", ops_done); end
    vectors++; if ({alu_a, alu_b, alu_cmd} !== 67'd0) begin miscompares++; $display("FAIL reset_alu_ops got %h/%h/%0d exp 0", alu_a, alu_b, alu_cmd); end
    vectors++; if ({resp_result, resp_carryout, resp_overflow, resp_zero} !== 35'd0) begin miscompares++; $display("FAIL reset_resp_regs got %h %b%b%b exp 0", resp_result, resp_carryout, resp_overflow, resp_zero); end
    vectors++; if ({req_ready0, req_ready1} !== 2'b00) begin miscompares++; $display("FAIL reset_ready got %b exp 00", {req_ready0, req_ready1}); end
  endtask

  task automatic test_directed;
    logic        p [3]   = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ta [3]  = '{32'd7000, 32'd2147483647, 32'd637483644};
    logic [31:0] tb [3]  = '{32'd14000, 32'd14000, 32'd637483644};
    logic [2:0]  tc [3]  = '{3'd0, 3'd0, 3'd1};
    logic [31:0] er [3]  = '{32'd21000, 32'd2147497647, 32'd0};
    logic [2:0]  ef [3]  = '{3'b000, 3'b010, 3'b101}; // {carry, overflow, zero}
    for (int i = 0; i < 3; i++) begin
      if (p[i]) begin req_valid1 = 1'b1; req_a1 = ta[i]; req_b1 = tb[i]; req_cmd1 = tc[i]; end
      else      begin req_valid0 = 1'b1; req_a0 = ta[i]; req_b0 = tb[i]; req_cmd0 = tc[i]; end
      #1;
      vectors++; if ({req_ready1, req_ready0} !== (p[i] ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL dir%0d_ready got %b exp port %0d", i, {req_ready1, req_ready0}, p[i]); end
      tick;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      vectors++; if ({busy, alu_a, alu_b, alu_cmd} !== {1'b1, ta[i], tb[i], tc[i]}) begin miscompares++; $display("FAIL dir%0d_exec got busy=%b %h/%h/%0d exp %h/%h/%0d", i, busy, alu_a, alu_b, alu_cmd, ta[i], tb[i], tc[i]); end
      vectors++; if ({resp_valid1, resp_valid0} !== 2'b00) begin miscompares++; $display("FAIL dir%0d_early_resp got %b exp 00", i, {resp_valid1, resp_valid0}); end
      tick;
      vectors++; if ({resp_valid1, resp_valid0} !== (p[i] ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL dir%0d_resp_valid got %b exp port %0d", i, {resp_valid1, resp_valid0}, p[i]); end
      vectors++; if (resp_result !== er[i]) begin miscompares++; $display("FAIL dir%0d_result got %0d exp %0d", i, resp_result, er[i]); end
      vectors++; if ({resp_carryout, resp_overflow, resp_zero} !== ef[i]) begin miscompares++; $display("FAIL dir%0d_flags got %b exp %b", i, {resp_carryout, resp_overflow, resp_zero}, ef[i]); end
      if (p[i]) resp_ready1 = 1'b1; else resp_ready0 = 1'b1;
      tick;
      resp_ready0 = 1'b0; resp_ready1 = 1'b0;
      model_last = p[i]; exp_ops++;
      vectors++; if ({busy, ops_done} !== {1'b0, exp_ops}) begin miscompares++; $display("FAIL dir%0d_done got busy=%b ops=%0d exp busy=0 ops=%0d", i, busy, ops_done, exp_ops); end
    end
  endtask

  task automatic test_alternate;
    int rem0, rem1, ngrant, nresp;
    test_reset;
    rem0 = 4; rem1 = 4; ngrant = 0; nresp = 0;
    req_a0 = 32'hC; req_b0 = 32'hA; req_cmd0 = 3'd7;
    req_a1 = 32'hC; req_b1 = 32'hA; req_cmd1 = 3'd7;
    resp_ready0 = 1'b1; resp_ready1 = 1'b1;
    for (int cyc = 0; cyc < 100 && nresp < 8; cyc++) begin
      req_valid0 = (rem0 > 0); req_valid1 = (rem1 > 0);
      #1;
      if (req_ready0 || req_ready1) begin
        vectors++; if ({req_ready1, req_ready0} !== ((ngrant % 2) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL alt_grant%0d got %b exp port %0d", ngrant, {req_ready1, req_ready0}, ngrant % 2); end
        if (req_ready1) rem1--; else rem0--;
        ngrant++;
      end
      if (resp_valid0 || resp_valid1) begin
        vectors++; if ({resp_valid1, resp_valid0, resp_result} !== {((nresp % 2) ? 2'b10 : 2'b01), 32'hE}) begin miscompares++; $display("FAIL alt_resp%0d got v=%b r=%h exp port %0d r=e", nresp, {resp_valid1, resp_valid0}, resp_result, nresp % 2); end
        nresp++;
      end
      tick;
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0; resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    exp_ops = 16'd8; model_last = 1'b1;
    vectors++; if (nresp !== 8 || ngrant !== 8) begin miscompares++; $display("FAIL alt_count got grants=%0d resps=%0d exp 8/8", ngrant, nresp); end
    vectors++; if (ops_done !== 16'd8) begin miscompares++; $display("FAIL alt_ops_done got %0d exp 8", ops_done); end
  endtask

  task automatic test_backpressure;
    req_valid0 = 1'b1; req_a0 = 32'h1234; req_b0 = 32'h00FF; req_cmd0 = 3'd4;
    #1;
    vectors++; if (req_ready0 !== 1'b1) begin miscompares++; $display("FAIL bp_accept got %b exp 1", req_ready0); end
    tick;
    req_valid0 = 1'b0;
    req_valid1 = 1'b1; req_a1 = 32'd5; req_b1 = 32'd6; req_cmd1 = 3'd0;
    tick;
    resp_ready1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++; if ({resp_valid0, resp_valid1, resp_result, req_ready1} !== {2'b10, 32'h34, 1'b0}) begin miscompares++; $display("FAIL bp_hold%0d got v=%b%b r=%h rdy1=%b exp v=10 r=34 rdy1=0", i, resp_valid0, resp_valid1, resp_result, req_ready1); end
      tick;
    end
    resp_ready1 = 1'b0; resp_ready0 = 1'b1;
    #1;
    vectors++; if (req_ready1 !== 1'b0) begin miscompares++; $display("FAIL bp_release_ready1 got %b exp 0", req_ready1); end
    tick;
    resp_ready0 = 1'b0; exp_ops++; model_last = 1'b0;
    vectors++; if ({req_ready1, req_ready0} !== 2'b10) begin miscompares++; $display("FAIL bp_next_grant got %b exp 10", {req_ready1, req_ready0}); end
    tick;
    req_valid1 = 1'b0;
    tick;
    vectors++; if ({resp_valid1, resp_result} !== {1'b1, 32'd11}) begin miscompares++; $display("FAIL bp_second_resp got v=%b r=%0d exp v=1 r=11", resp_valid1, resp_result); end
    resp_ready1 = 1'b1;
    tick;
    resp_ready1 = 1'b0; exp_ops++; model_last = 1'b1;
    vectors++; if (ops_done !== exp_ops) begin miscompares++; $display("FAIL bp_ops_done got %0d exp %0d", ops_done, exp_ops); end
  endtask

  task automatic test_reset_mid_exec;
    req_valid0 = 1'b1; req_a0 = 32'hFF; req_b0 = 32'h0F; req_cmd0 = 3'd4;
    tick;
    req_valid0 = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_exec_busy got %b exp 1", busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0; model_last = 1'b1; exp_ops = 16'd0;
    vectors++; if ({resp_valid0, resp_valid1, busy, ops_done} !== 19'd0) begin miscompares++; $display("FAIL rst_exec_state got v=%b%b busy=%b ops=%0d exp all 0", resp_valid0, resp_valid1, busy, ops_done); end
    vectors++; if ({alu_a, alu_cmd, resp_result} !== 67'd0) begin miscompares++; $display("FAIL rst_exec_regs got a=%h cmd=%0d r=%h exp 0", alu_a, alu_cmd, resp_result); end
    tick;
    vectors++; if ({resp_valid0, resp_valid1} !== 2'b00) begin miscompares++; $display("FAIL rst_exec_no_resp got %b exp 00", {resp_valid0, resp_valid1}); end
    req_valid0 = 1'b1; req_valid1 = 1'b1; req_cmd0 = 3'd2; req_cmd1 = 3'd2;
    #1;
    vectors++; if ({req_ready1, req_ready0} !== 2'b01) begin miscompares++; $display("FAIL rst_tie got %b exp 01", {req_ready1, req_ready0}); end
    tick;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    tick;
    resp_ready0 = 1'b1;
    tick;
    resp_ready0 = 1'b0; model_last = 1'b0; exp_ops = 16'd1;
    vectors++; if (ops_done !== exp_ops) begin miscompares++; $display("FAIL rst_after_ops got %0d exp %0d", ops_done, exp_ops); end
  endtask

  task automatic test_random;
    logic        v0, v1, w;
    logic [1:0]  r;
    logic [31:0] a0, b0, a1, b1, ea, eb;
    logic [2:0]  c0, c1, ec;
    logic [34:0] exp;
    int          stall;
    for (int n = 0; n < 40; n++) begin
      r = 2'($urandom_range(1, 3));
      v0 = r[0]; v1 = r[1];
      a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom; c0 = 3'($urandom_range(0, 7));
      a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom; c1 = 3'($urandom_range(0, 7));
      w = (v0 && v1) ? ~model_last : v1;
      ea = w ? a1 : a0; eb = w ? b1 : b0; ec = w ? c1 : c0;
      exp = alu_ref(ea, eb, ec);
      req_valid0 = v0; req_a0 = a0; req_b0 = b0; req_cmd0 = c0;
      req_valid1 = v1; req_a1 = a1; req_b1 = b1; req_cmd1 = c1;
      #1;
      vectors++; if ({req_ready1, req_ready0} !== (w ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rnd%0d_grant got %b exp port %0d (v=%b%b)", n, {req_ready1, req_ready0}, w, v1, v0); end
      tick;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      vectors++; if ({alu_a, alu_b, alu_cmd} !== {ea, eb, ec}) begin miscompares++; $display("FAIL rnd%0d_alu_ops got %h/%h/%0d exp %h/%h/%0d", n, alu_a, alu_b, alu_cmd, ea, eb, ec); end
      tick;
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        vectors++; if ({resp_valid1, resp_valid0} !== (w ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rnd%0d_resp_valid got %b exp port %0d", n, {resp_valid1, resp_valid0}, w); end
        vectors++; if ({resp_carryout, resp_overflow, resp_zero, resp_result} !== exp) begin miscompares++; $display("FAIL rnd%0d_resp got c=%b v=%b z=%b r=%h exp %b%b%b r=%h", n, resp_carryout, resp_overflow, resp_zero, resp_result, exp[34], exp[33], exp[32], exp[31:0]); end
        if (w) begin resp_ready1 = (s == stall); resp_ready0 = $urandom_range(0, 1) == 1; end
        else   begin resp_ready0 = (s == stall); resp_ready1 = $urandom_range(0, 1) == 1; end
        tick;
      end
      resp_ready0 = 1'b0; resp_ready1 = 1'b0;
      model_last = w; exp_ops++;
      vectors++; if ({busy, ops_done} !== {1'b0, exp_ops}) begin miscompares++; $display("FAIL rnd%0d_done got busy=%b ops=%0d exp busy=0 ops=%0d", n, busy, ops_done, exp_ops); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_cmd0 = 3'd0; req_cmd1 = 3'd0;
    resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    model_last = 1'b1; exp_ops = 16'd0;
    test_reset;
    test_directed;
    test_alternate;
    test_backpressure;
    test_reset_mid_exec;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
